mem_bist: RTL and testbench
===========================

# mem_bist

Built-in self-test sequencer for the 16-bit data memory of the accumulator processor. It drives the memory's write/read port (`addra`, `DataWrite`, `MemWrite`, `DataOut`) as the initiator. It writes an address-derived pattern over a strided address range, reads every location back, compares each result, and reports pass/fail with a failure count and the first failing address. It sits between the top-level test/debug logic and the memory, muxed in front of the CPU datapath's memory port.

## Interface
- `START_ADDR`, default 0: first address tested.
- `END_ADDR`, default 20: last address tested, inclusive. `END_ADDR >= START_ADDR` is required.
- `STRIDE`, default 2: address increment, at least 1.
- `MULT`, default 100: pattern multiplier. Expected data = (addr × MULT) mod 2^16.
- `clk` in 1: the single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `start` in 1: begin a test. Sampled only in IDLE or DONE.
- `DataOut` in 16: memory read data. Registered memory: valid the cycle after `addra` is presented.
- `addra` out 16: memory address (registered).
- `DataWrite` out 16: memory write data (registered).
- `MemWrite` out 1: memory write enable (registered). The memory writes on the rising edge at the end of a cycle in which it is high.
- `busy` out 1: high in WRITE, READ and DRAIN.
- `done` out 1: high in DONE, held until the next start or reset.
- `pass` out 1: `done` && `fail_count` == 0.
- `fail_count` out 8: number of mismatches, saturating at 255.
- `first_fail_addr` out 16: address of the first mismatch. 0 if there are none.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- Reset values: state IDLE, with `addra`, `DataWrite`, `MemWrite`, `busy`, `done`, `pass`, `fail_count`, `first_fail_addr` all 0.
- IDLE or DONE with `start`=1:
  - go to WRITE;
  - set `addra` = START_ADDR, `DataWrite` = START_ADDR×MULT, `MemWrite` = 1;
  - clear `fail_count`, `first_fail_addr` and `done`.
- WRITE: each cycle performs one write.
  - If the next address (addr + STRIDE, computed 17 bits wide so it cannot wrap) is ≤ END_ADDR, advance `addra` and `DataWrite`.
  - Otherwise go to READ with `addra` = START_ADDR and `MemWrite` = 0.
- READ: each cycle presents one address with `MemWrite` = 0.
  - The expected value and a compare-valid flag are pipelined one stage.
  - The compare happens in the following cycle against `DataOut`.
  - After the last address, go to DRAIN.
- DRAIN: one cycle that completes the final compare, then go to DONE.
- Compare, on a mismatch:
  - increment `fail_count`, saturating at 255;
  - if this is the first mismatch of the run, latch the address into `first_fail_addr`.
- `start` in WRITE, READ or DRAIN is ignored.
- `reset` asserted in any state aborts the run immediately; outputs take their reset values.

## Timing
- N = (END_ADDR − START_ADDR)/STRIDE + 1. With defaults, N = 11 (addresses 0, 2, …, 20).
- Cycle 0 is the edge at which `start` is sampled.
  - WRITE occupies cycles 1..N.
  - READ occupies cycles N+1..2N.
  - DRAIN is cycle 2N+1.
  - `done` rises in cycle 2N+2 (cycle 24 with defaults).
- `busy` is high in cycles 1..2N+1.
- `MemWrite` is high in exactly N cycles per run.
- The compare for the read presented in cycle c uses `DataOut` in cycle c+1.
- Boundaries:
  - END_ADDR = START_ADDR gives N = 1.
  - An address range ending near 0xFFFF must not wrap back to a low address; the 17-bit next-address compare guarantees termination.
  - Pattern products wider than 16 bits are truncated.

## Test plan
- Ideal memory model, defaults, `start` pulsed at cycle 0:
  - 11 writes of 0, 200, …, 2000 to addresses 0..20;
  - `done`=1 at cycle 24, `pass`=1, `fail_count`=0, `first_fail_addr`=0.
- Memory with bit 3 of data stuck at 0, defaults:
  - addresses whose pattern has bit 3 set (e.g. addr 2 → 200 = 0xC8) fail;
  - `first_fail_addr`=2, `fail_count` equals the count of such addresses, `pass`=0.
- Memory that always returns 0, START=0, END=299, STRIDE=1:
  - 299 mismatches (addr 0 matches);
  - `fail_count`=255 (saturated), `first_fail_addr`=1, `done` at cycle 602.
- `reset` asserted at cycle 15 of a default run:
  - all outputs go to 0 immediately and the state is IDLE;
  - a new `start` then completes normally with `pass`=1.
- `start` re-pulsed at cycles 5 and 14 of a run: ignored, and `done` still rises at cycle 24.
- After a failing run, `start` asserted in DONE:
  - `done`, `fail_count` and `first_fail_addr` clear on the next cycle;
  - with an ideal memory, the second run ends with `pass`=1.

Source files
------------

// File: rtl/mem_bist.sv
// Memory BIST sequencer: writes an address-derived pattern over a strided range,
// reads it back through a registered memory port and reports mismatches.
module mem_bist #(
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 20,
  parameter int unsigned STRIDE     = 2,
  parameter int unsigned MULT       = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] DataOut,
  output logic [15:0] addra,
  output logic [15:0] DataWrite,
  output logic        MemWrite,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_count,
  output logic [15:0] first_fail_addr
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [15:0] START_A    = 16'(START_ADDR);
  localparam logic [16:0] END_EXT    = 17'(END_ADDR);
  localparam logic [16:0] STRIDE_EXT = 17'(STRIDE);

  function automatic logic [15:0] pattern(input logic [15:0] a);
    logic [31:0] p;
    p = 32'(a) * 32'(MULT);
    return p[15:0];
  endfunction

  state_t      state, state_next;
  logic        launch;
  logic        last;
  logic [16:0] next_addr;
  logic        cmp_valid;
  logic [15:0] cmp_data;
  logic [15:0] cmp_addr;

  // One bit wider than the address so a range ending near 0xFFFF cannot wrap.
  assign next_addr = {1'b0, addra} + STRIDE_EXT;
  assign last      = next_addr > END_EXT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_next = WRITE;
        launch     = 1'b1;
      end
      WRITE:   if (last) state_next = READ;
      READ:    if (last) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addra           <= '0;
      DataWrite       <= '0;
      MemWrite        <= 1'b0;
      fail_count      <= '0;
      first_fail_addr <= '0;
      cmp_valid       <= 1'b0;
      cmp_data        <= '0;
      cmp_addr        <= '0;
    end else begin
      // The read presented this cycle returns next cycle; carry its expectation along.
      cmp_valid <= (state == READ);
      cmp_data  <= pattern(addra);
      cmp_addr  <= addra;

      if (cmp_valid && (DataOut != cmp_data)) begin
        if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
        if (fail_count == 8'h00) first_fail_addr <= cmp_addr;
      end

      if (launch) begin
        addra           <= START_A;
        DataWrite       <= pattern(START_A);
        MemWrite        <= 1'b1;
        fail_count      <= '0;
        first_fail_addr <= '0;
      end else begin
        case (state)
          WRITE: begin
            if (last) begin
              addra    <= START_A;
              MemWrite <= 1'b0;
            end else begin
              addra     <= next_addr[15:0];
              DataWrite <= pattern(next_addr[15:0]);
            end
          end
          READ:    if (!last) addra <= next_addr[15:0];
          default: ;
        endcase
      end
    end
  end

  assign busy = (state == WRITE) || (state == READ) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (fail_count == 8'h00);

endmodule

// File: tb/tb_mem_bist.sv
// Scoreboard bench for mem_bist: four configurations, each with its own
// faultable registered memory, write monitor and end-of-run monitor.
module tb_mem_bist;

  localparam int NI = 4;
  localparam int P_START  [NI] = '{0,   0,   'hFFF0, 5};
  localparam int P_END    [NI] = '{20,  299, 'hFFFF, 5};
  localparam int P_STRIDE [NI] = '{2,   1,   7,      3};
  localparam int P_MULT   [NI] = '{100, 100, 1234,   9};

  // Memory fault modes: 0 ideal, 1 data bit 3 stuck at 0, 2 reads 0, 3 per-address xor.
  typedef struct {
    int          done_cyc;
    logic [7:0]  fails;
    logic [15:0] first;
    logic        pass_bit;
  } run_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        start           [NI];
  logic [15:0] data_out        [NI];
  logic [15:0] addra           [NI];
  logic [15:0] data_write      [NI];
  logic        mem_write       [NI];
  logic        busy            [NI];
  logic        done            [NI];
  logic        pass            [NI];
  logic [7:0]  fail_count      [NI];
  logic [15:0] first_fail_addr [NI];

  logic [15:0] mem  [NI][65536];
  logic [15:0] flip [NI][65536];
  int          fault_mode [NI];
  run_t        run_q [NI][$];
  wr_t         wr_q  [NI][$];

  int cyc;
  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic note_fail(input string msg);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", msg, cyc);
  endtask

  for (genvar g = 0; g < NI; g++) begin : lane
    mem_bist #(
      .START_ADDR(P_START[g]),
      .END_ADDR  (P_END[g]),
      .STRIDE    (P_STRIDE[g]),
      .MULT      (P_MULT[g])
    ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start[g]),
      .DataOut        (data_out[g]),
      .addra          (addra[g]),
      .DataWrite      (data_write[g]),
      .MemWrite       (mem_write[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .pass           (pass[g]),
      .fail_count     (fail_count[g]),
      .first_fail_addr(first_fail_addr[g])
    );

    always @(posedge clk) begin
      if (mem_write[g]) mem[g][addra[g]] <= data_write[g];
      case (fault_mode[g])
        1:       data_out[g] <= mem[g][addra[g]] & ~16'h0008;
        2:       data_out[g] <= 16'h0000;
        3:       data_out[g] <= mem[g][addra[g]] ^ flip[g][addra[g]];
        default: data_out[g] <= mem[g][addra[g]];
      endcase
    end

    initial begin
      logic done_q;
      logic busy_q;
      run_t e;
      wr_t  w;
      done_q = 1'b0;
      busy_q = 1'b0;
      forever begin
        @(negedge clk);
        if (reset) begin
          done_q = 1'b0;
          busy_q = 1'b0;
        end else begin
          if (mem_write[g]) begin
            if (wr_q[g].size() == 0) begin
              note_fail($sformatf("i%0d unexpected write addr %0h", g, addra[g]));
            end else begin
              w = wr_q[g].pop_front();
              check($sformatf("i%0d write addr", g), addra[g], w.a);
              check($sformatf("i%0d write data @%0h", g, w.a), data_write[g], w.d);
            end
          end
          if (done[g] && !done_q) begin
            if (run_q[g].size() == 0) begin
              note_fail($sformatf("i%0d unexpected done", g));
            end else begin
              e = run_q[g].pop_front();
              check($sformatf("i%0d done cycle", g), cyc, e.done_cyc);
              check($sformatf("i%0d fail_count", g), fail_count[g], e.fails);
              check($sformatf("i%0d first_fail_addr", g), first_fail_addr[g], e.first);
              check($sformatf("i%0d pass", g), pass[g], e.pass_bit);
              check($sformatf("i%0d busy in done", g), busy[g], 0);
              check($sformatf("i%0d busy before done", g), busy_q, 1);
              check($sformatf("i%0d writes outstanding", g), wr_q[g].size(), 0);
              wr_q[g].delete();
            end
          end
          done_q = done[g];
          busy_q = busy[g];
        end
      end
    end
  end

  // Reference: walk the address list with plain integers, derive each write
  // and decide from the fault definition whether its readback mismatches.
  task automatic push_run(input int g);
    int          n;
    int          fails;
    int          first;
    logic [15:0] d;
    logic        bad;
    n     = 0;
    fails = 0;
    first = 0;
    for (int a = P_START[g]; a <= P_END[g]; a += P_STRIDE[g]) begin
      d = 16'((longint'(a) * longint'(P_MULT[g])) % 65536);
      wr_q[g].push_back('{a: 16'(a), d: d});
      case (fault_mode[g])
        1:       bad = d[3];
        2:       bad = (d != 16'h0000);
        3:       bad = (flip[g][a] != 16'h0000);
        default: bad = 1'b0;
      endcase
      if (bad) begin
        if (fails == 0) first = a;
        fails++;
      end
      n++;
    end
    run_q[g].push_back('{done_cyc: cyc + 1 + 2 * n + 1,
                         fails:    (fails > 255) ? 8'hFF : 8'(fails),
                         first:    16'(first),
                         pass_bit: (fails == 0)});
  endtask

  // Called at a falling edge; returns at the falling edge after start was sampled.
  task automatic launch(input int g, input int mode);
    fault_mode[g] = mode;
    push_run(g);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    int k;
    k = 0;
    while ((run_q[g].size() != 0) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    if (run_q[g].size() != 0) begin
      note_fail($sformatf("i%0d timeout waiting for done", g));
      run_q[g].delete();
      wr_q[g].delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input int g, input string tag);
    check($sformatf("%s i%0d addra", tag, g), addra[g], 0);
    check($sformatf("%s i%0d DataWrite", tag, g), data_write[g], 0);
    check($sformatf("%s i%0d MemWrite", tag, g), mem_write[g], 0);
    check($sformatf("%s i%0d busy", tag, g), busy[g], 0);
    check($sformatf("%s i%0d done", tag, g), done[g], 0);
    check($sformatf("%s i%0d pass", tag, g), pass[g], 0);
    check($sformatf("%s i%0d fail_count", tag, g), fail_count[g], 0);
    check($sformatf("%s i%0d first_fail_addr", tag, g), first_fail_addr[g], 0);
  endtask

  task automatic randomize_flips(input int g);
    for (int a = P_START[g]; a <= P_END[g]; a += P_STRIDE[g])
      flip[g][a] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
  endtask

  initial begin
    int pick [3];
    int g;
    int mode;
    pick        = '{0, 2, 3};
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i]      = 1'b0;
      fault_mode[i] = 0;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) check_reset_state(i, "por");
    reset = 1'b0;
    @(negedge clk);

    // Ideal memory, defaults, then bit 3 stuck at 0.
    launch(0, 0);
    wait_done(0, 100);
    launch(0, 1);
    wait_done(0, 100);

    // Restart straight from a failing DONE with an ideal memory.
    launch(0, 0);
    check("restart done", done[0], 0);
    check("restart fail_count", fail_count[0], 0);
    check("restart first_fail_addr", first_fail_addr[0], 0);
    wait_done(0, 100);

    // Long run against a memory that always reads 0: count saturates.
    launch(1, 2);
    wait_done(1, 800);

    // Reset in cycle 15 aborts the run; a fresh start completes.
    launch(0, 0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state(0, "abort");
    run_q[0].delete();
    wr_q[0].delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    launch(0, 0);
    wait_done(0, 100);

    // Start re-pulsed mid-run must be ignored.
    launch(0, 0);
    repeat (4) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (8) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 100);

    // Range ending at 0xFFFF, and a single-address range.
    launch(2, 0);
    wait_done(2, 100);
    launch(3, 0);
    wait_done(3, 100);

    for (int k = 0; k < 12; k++) begin
      g    = pick[$urandom_range(0, 2)];
      mode = $urandom_range(0, 3);
      if (mode == 3) randomize_flips(g);
      launch(g, mode);
      wait_done(g, 100);
    end

    for (int i = 0; i < NI; i++) check($sformatf("i%0d runs pending", i), run_q[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
